// File: rtl/ad4008_readout_ctrl.sv
// ad4008_readout_ctrl
//
// Sequences one AD4008-style SAR ADC over its three-wire interface. The block
// raises cnv and holds it, then waits out the conversion. It then clocks
// ADC_WIDTH sck pulses, shifts sdo in MSB first and presents the result as a
// parallel word with a one-cycle valid strobe. A conversion starts on an
// external trigger or, when SAMPLE_PERIOD_CYCLES > 0, from a free-running
// period timer.
//
// Optional feature macro: AD4008_BUSY_POLL_EN
//   defined   : the conversion wait ends early once a synchronised sdo reads low.
//               If sdo is still high at 2*CONV_CYCLES after cnv rise, the frame
//               aborts (no sample_valid, overrun pulses).
//   undefined : fixed CONV_CYCLES wait; sdo is only looked at while sck is low.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   gates new conversion starts
//   trigger      in   single-cycle start request (trigger mode only)
//   sdo          in   ADC serial data
//   cnv          out  ADC convert-start (registered)
//   sck          out  ADC serial clock (registered, idle low)
//   sample_data  out  last captured result
//   sample_valid out  one-cycle strobe, sample_data updated
//   busy         out  high from start acceptance through the sample_valid cycle
//   overrun      out  one-cycle pulse when a start request is dropped

module ad4008_readout_ctrl #(
  parameter int ADC_WIDTH            = 16,
  parameter int CNV_HIGH_CYCLES      = 4,
  parameter int CONV_CYCLES          = 32,
  parameter int SCK_HALF_CYCLES      = 2,
  parameter int SAMPLE_PERIOD_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 trigger,
  input  logic                 sdo,
  output logic                 cnv,
  output logic                 sck,
  output logic [ADC_WIDTH-1:0] sample_data,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TW = $clog2(2 * CONV_CYCLES + 1);
  localparam int HW = (SCK_HALF_CYCLES > 1) ? $clog2(SCK_HALF_CYCLES + 1) : 1;
  localparam int BW = $clog2(ADC_WIDTH + 1);
  localparam int PW = (SAMPLE_PERIOD_CYCLES > 1) ? $clog2(SAMPLE_PERIOD_CYCLES) : 1;

  localparam logic [TW-1:0] CNV_LAST   = TW'(CNV_HIGH_CYCLES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(SCK_HALF_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(ADC_WIDTH - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(SAMPLE_PERIOD_CYCLES - 1);
`ifdef AD4008_BUSY_POLL_EN
  localparam logic [TW-1:0] ABORT_LAST = TW'(2 * CONV_CYCLES - 1);
`else
  localparam logic [TW-1:0] CONV_LAST  = TW'(CONV_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, CNV_HIGH, CONV_WAIT, SCK_HI, SCK_LO, DONE
  } state_t;

  state_t                 state_q;
  logic                   cnv_q;
  logic                   sck_q;
  logic                   busy_q;
  logic                   sample_valid_q;
  logic                   overrun_q;
  logic [ADC_WIDTH-1:0]   sample_data_q;
  logic [ADC_WIDTH-1:0]   shift_q;
  logic [TW-1:0]          tcnt_q;     // cycles since cnv rise
  logic [HW-1:0]          hcnt_q;     // cycles within the current sck half-period
  logic [BW-1:0]          bit_q;      // bits captured this frame
  logic [PW-1:0]          period_q;
  logic                   period_wrap_d;
  logic                   start_req_d;
  logic [ADC_WIDTH-1:0]   shift_d;

  // Period timer free-runs while enabled, independent of the frame state.
  assign period_wrap_d = (SAMPLE_PERIOD_CYCLES > 0) && enable && (period_q == PER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
    end else if (!enable || (SAMPLE_PERIOD_CYCLES == 0) || period_wrap_d) begin
      period_q <= '0;
    end else begin
      period_q <= period_q + 1'b1;
    end
  end

  assign start_req_d = enable && ((SAMPLE_PERIOD_CYCLES > 0) ? period_wrap_d : trigger);
  assign shift_d     = {shift_q[ADC_WIDTH-2:0], sdo};

`ifdef AD4008_BUSY_POLL_EN
  logic [1:0] sdo_sync_q;
  logic       conv_ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_sync_q <= '0;
    end else begin
      sdo_sync_q <= {sdo_sync_q[0], sdo};
    end
  end

  // The ADC holds sdo high while converting and drops it when the result is ready.
  assign conv_ready_d = ~sdo_sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnv_q          <= 1'b0;
      sck_q          <= 1'b0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      sample_data_q  <= '0;
      shift_q        <= '0;
      tcnt_q         <= '0;
      hcnt_q         <= '0;
      bit_q          <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      overrun_q      <= start_req_d && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (start_req_d) begin
            state_q <= CNV_HIGH;
            cnv_q   <= 1'b1;
            busy_q  <= 1'b1;
            tcnt_q  <= '0;
          end
        end
        CNV_HIGH: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == CNV_LAST) begin
            cnv_q   <= 1'b0;
            state_q <= CONV_WAIT;
          end
        end
        CONV_WAIT: begin
          tcnt_q <= tcnt_q + 1'b1;
`ifdef AD4008_BUSY_POLL_EN
          if (conv_ready_d) begin
            state_q <= SCK_HI;
            sck_q   <= 1'b1;
            hcnt_q  <= '0;
            bit_q   <= '0;
          end else if (tcnt_q == ABORT_LAST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            overrun_q <= 1'b1;
          end
`else
          if (tcnt_q == CONV_LAST) begin
            state_q <= SCK_HI;
            sck_q   <= 1'b1;
            hcnt_q  <= '0;
            bit_q   <= '0;
          end
`endif
        end
        SCK_HI: begin
          if (hcnt_q == HALF_LAST) begin
            sck_q   <= 1'b0;
            hcnt_q  <= '0;
            state_q <= SCK_LO;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        SCK_LO: begin
          if (hcnt_q == HALF_LAST) begin
            hcnt_q  <= '0;
            shift_q <= shift_d;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              // Outputs are registered, so the word and strobe are loaded on
              // entry to DONE and are visible for the DONE cycle itself.
              state_q        <= DONE;
              sample_data_q  <= shift_d;
              sample_valid_q <= 1'b1;
            end else begin
              state_q <= SCK_HI;
              sck_q   <= 1'b1;
            end
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cnv          = cnv_q;
  assign sck          = sck_q;
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ad4008_readout_ctrl.sv
// Testbench for ad4008_readout_ctrl (default build).
// Instance a: trigger mode with default timing. Instance b: periodic mode with
// a 200-cycle period. Each instance is paired with a behavioural ADC. The ADC
// restarts its bit stream on cnv rise and presents the next result bit, MSB
// first, after every sck falling edge.

module tb_ad4008_readout_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         enable_a, trigger_a, sdo_a, cnv_a, sck_a, valid_a, busy_a, ovr_a;
  logic [W-1:0] data_a;
  logic         enable_b, trigger_b, sdo_b, cnv_b, sck_b, valid_b, busy_b, ovr_b;
  logic [W-1:0] data_b;

  int checks   = 0;
  int failures = 0;

  ad4008_readout_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .trigger(trigger_a), .sdo(sdo_a),
    .cnv(cnv_a), .sck(sck_a), .sample_data(data_a), .sample_valid(valid_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  ad4008_readout_ctrl #(.SAMPLE_PERIOD_CYCLES(200)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .trigger(trigger_b), .sdo(sdo_b),
    .cnv(cnv_b), .sck(sck_b), .sample_data(data_b), .sample_valid(valid_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  // Behavioural ADCs: fall count 0 after cnv rise, bit k shown after fall k+1.
  logic [W-1:0] word_a, word_b, sh_a, sh_b;
  int fall_a = 0;
  int fall_b = 0;

  always @(posedge cnv_a or negedge sck_a) begin
    if (cnv_a) fall_a = 0;
    else       fall_a = fall_a + 1;
  end
  always @(posedge cnv_b or negedge sck_b) begin
    if (cnv_b) fall_b = 0;
    else       fall_b = fall_b + 1;
  end
  assign sh_a  = word_a << (fall_a - 1);
  assign sh_b  = word_b << (fall_b - 1);
  assign sdo_a = (fall_a >= 1 && fall_a <= W) ? sh_a[W-1] : 1'b0;
  assign sdo_b = (fall_b >= 1 && fall_b <= W) ? sh_b[W-1] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame on instance a. Timing expectations follow from the frame rules:
  // cnv high 4 cycles, first sck 32 cycles after cnv rise, 16 bits of 4 cycles,
  // so the strobe appears 96 cycles after cnv rise. n counts negedges after the
  // edge that accepted the trigger.
  task automatic run_a(input logic [W-1:0] w, input bit extra, input bit drop_en,
                       input bit btb, input string tag);
    int cnv_hi, first_sck, rises, valid_n, valid_cnt, ovr_cnt, ovr_n;
    logic sck_prev, busy96, busy97, cnv98;
    logic [W-1:0] got;
    cnv_hi = 0; first_sck = -1; rises = 0; valid_n = -1; valid_cnt = 0;
    ovr_cnt = 0; ovr_n = -1; sck_prev = 1'b0; busy96 = 1'b0; busy97 = 1'b1;
    cnv98 = 1'b0; got = '0;
    word_a = w;
    @(negedge clk);
    trigger_a = 1'b1;
    for (int n = 0; n <= 110; n++) begin
      @(negedge clk);
      trigger_a = (extra && n == 29) || (btb && n == 97);
      if (drop_en && n == 40) enable_a = 1'b0;
      if (cnv_a && n < 8) cnv_hi++;
      if (sck_a && first_sck < 0) first_sck = n;
      if (sck_a && !sck_prev) rises++;
      sck_prev = sck_a;
      if (valid_a) begin valid_cnt++; valid_n = n; got = data_a; end
      if (ovr_a) begin ovr_cnt++; ovr_n = n; end
      if (n == 96) busy96 = busy_a;
      if (n == 97) busy97 = busy_a;
      if (n == 98) cnv98 = cnv_a;
    end
    trigger_a = 1'b0;
    check({tag, ".cnv_cycles"}, cnv_hi, 4);
    check({tag, ".first_sck"}, first_sck, 32);
    check({tag, ".sck_pulses"}, rises, 16);
    check({tag, ".valid_count"}, valid_cnt, 1);
    check({tag, ".valid_cycle"}, valid_n, 96);
    check({tag, ".data"}, {16'h0, got}, {16'h0, w});
    check({tag, ".busy_at_valid"}, {31'h0, busy96}, 1);
    check({tag, ".busy_after"}, {31'h0, busy97}, 0);
    check({tag, ".overrun_count"}, ovr_cnt, extra ? 1 : 0);
    if (extra) check({tag, ".overrun_cycle"}, ovr_n, 30);
    if (btb) begin
      check({tag, ".btb_cnv"}, {31'h0, cnv98}, 1);
      repeat (120) @(negedge clk);
    end
  endtask

  initial begin
    int vcnt, ovr_cnt, quiet_bad;
    int vn[$];
    logic [W-1:0] vd[$];
    logic [W-1:0] rnd_b;

    rst_n = 1'b0; enable_a = 1'b0; trigger_a = 1'b0; enable_b = 1'b0; trigger_b = 1'b0;
    word_a = '0; word_b = '0;
    repeat (3) @(negedge clk);
    check("reset.cnv", {31'h0, cnv_a}, 0);
    check("reset.sck", {31'h0, sck_a}, 0);
    check("reset.busy", {31'h0, busy_a}, 0);
    check("reset.valid", {31'h0, valid_a}, 0);
    check("reset.overrun", {31'h0, ovr_a}, 0);
    check("reset.data", {16'h0, data_a}, 0);
    rst_n = 1'b1;
    enable_a = 1'b1;
    repeat (5) @(negedge clk);

    // Directed frames
    run_a(16'hA5C3, 1'b0, 1'b0, 1'b0, "f_a5c3");
    run_a(16'h3C5A, 1'b1, 1'b0, 1'b0, "f_overrun");
    run_a(16'h8001, 1'b0, 1'b0, 1'b1, "f_btb");

    // Randomised frames with random idle gaps
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      run_a(W'($urandom), 1'b0, 1'b0, 1'b0, "f_rand");
    end

    // Reset in the middle of a frame
    word_a = W'($urandom);
    @(negedge clk); trigger_a = 1'b1;
    @(negedge clk); trigger_a = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.cnv", {31'h0, cnv_a}, 0);
    check("midrst.sck", {31'h0, sck_a}, 0);
    check("midrst.busy", {31'h0, busy_a}, 0);
    check("midrst.data", {16'h0, data_a}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (valid_a || busy_a || cnv_a || sck_a) quiet_bad++;
    end
    check("midrst.no_activity", quiet_bad, 0);
    run_a(16'h5AA5, 1'b0, 1'b0, 1'b0, "f_after_rst");

    // Enable dropped mid-frame, then triggers must be ignored
    run_a(16'hC0DE, 1'b0, 1'b1, 1'b0, "f_en_drop");
    quiet_bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      trigger_a = (n % 10 == 3);
      if (busy_a || cnv_a || ovr_a || valid_a) quiet_bad++;
    end
    trigger_a = 1'b0;
    check("en_off.ignored", quiet_bad, 0);
    enable_a = 1'b1;

    // Periodic instance: first start 200 cycles after enable, then every 200.
    // trigger_b is held high the whole time and must have no effect.
    rnd_b = W'($urandom);
    word_b = 16'h0001;
    trigger_b = 1'b1;
    @(negedge clk);
    enable_b = 1'b1;
    vcnt = 0; ovr_cnt = 0;
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      if (ovr_b) ovr_cnt++;
      if (valid_b) begin
        vn.push_back(n);
        vd.push_back(data_b);
        vcnt++;
        word_b = (vcnt == 1) ? 16'hFFFF : rnd_b;
      end
    end
    enable_b = 1'b0;
    trigger_b = 1'b0;
    check("per.valid_count", vcnt, 3);
    check("per.overrun", ovr_cnt, 0);
    if (vcnt == 3) begin
      check("per.first_cycle", vn[0], 296);
      check("per.interval1", vn[1] - vn[0], 200);
      check("per.interval2", vn[2] - vn[1], 200);
      check("per.data0", {16'h0, vd[0]}, 32'h0001);
      check("per.data1", {16'h0, vd[1]}, 32'hFFFF);
      check("per.data2", {16'h0, vd[2]}, {16'h0, rnd_b});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad4008_readout_ctrl.md
# ad4008_readout_ctrl

Synthesizable controller that sequences one AD4008-style SAR ADC over its three-wire interface (cnv, sck, sdo). It starts a conversion, holds cnv for a programmed time and waits out the conversion time. It then generates sck, shifts the result in MSB first and presents it as a parallel word with a one-cycle valid strobe. It sits between the ADC pins (or the ADC behavioural model in simulation) and the sample-processing logic. Conversions start on an external trigger or from an internal period timer.

## Interface
- ADC_WIDTH, 16: result width in bits and number of sck pulses per frame.
- CNV_HIGH_CYCLES, 4: clk cycles cnv is held high; must be ≥1 and < CONV_CYCLES.
- CONV_CYCLES, 32: clk cycles from cnv rise to first sck rise; covers t_conv (320 ns at 100 MHz > 290 ns).
- SCK_HALF_CYCLES, 2: clk cycles per sck half-period; ≥1.
- SAMPLE_PERIOD_CYCLES, 0: 0 = trigger mode; >0 = free-running start every N cycles.
- clk  in  1  system clock; sole clock of the block.
- rst_n  in  1  asynchronous, active-low reset; removal synchronous to clk.
- enable  in  1  gates new conversion starts.
- trigger  in  1  single-cycle start request (trigger mode only; ignored when SAMPLE_PERIOD_CYCLES>0).
- sdo  in  1  ADC serial data.
- cnv  out  1  ADC convert-start, registered.
- sck  out  1  ADC serial clock, registered, idle low.
- sample_data  out  ADC_WIDTH  last captured result; holds until next frame completes.
- sample_valid  out  1  one-cycle strobe, sample_data updated this cycle.
- busy  out  1  high from start acceptance through the sample_valid cycle.
- overrun  out  1  one-cycle pulse when a start request is dropped.

## Operation
- Reset values: cnv=0, sck=0, sample_data=0, sample_valid=0, busy=0, overrun=0, state IDLE, all counters 0.
- States: IDLE, CNV_HIGH, CONV_WAIT, SCK_HI, SCK_LO, DONE.
- IDLE: a start event is (trigger mode) trigger=1 and enable=1, or (periodic mode) the period counter wrapping while enable=1. On a start event go to CNV_HIGH. Set cnv=1 and busy=1.
- CNV_HIGH: hold for CNV_HIGH_CYCLES, then drive cnv=0 and go to CONV_WAIT. The ADC only reports ready if cnv is low when conversion ends.
- CONV_WAIT: leave when CONV_CYCLES have elapsed since cnv rise. Go to SCK_HI with sck=1 and bit counter=0.
- SCK_HI: hold SCK_HALF_CYCLES, then drive sck=0 and go to SCK_LO. The ADC updates sdo on the sck falling edge.
- SCK_LO: hold SCK_HALF_CYCLES. On the last cycle, shift sdo into a shift register at the LSB, so the first bit captured ends at the MSB. Increment the bit counter. If the count reaches ADC_WIDTH go to DONE; otherwise go to SCK_HI with sck=1.
- DONE: one cycle. sample_data receives the shift register, sample_valid=1, busy stays 1. Then go to IDLE.
- Start requests arriving while busy=1 are dropped and pulse overrun for one cycle. No queueing.
- The periodic counter free-runs while enable=1 regardless of state. It resets to 0 when enable=0.
- enable deasserted mid-frame: the current frame completes normally; no new start is accepted.
- Reset mid-frame: all outputs return to reset values immediately. The partial result is discarded.

## Timing
- Trigger sampled high at edge k: cnv=1 from edge k+1 for CNV_HIGH_CYCLES cycles.
- First sck rise at edge k+1+CONV_CYCLES.
- Each bit takes 2·SCK_HALF_CYCLES cycles.
- sample_valid is high for the cycle after edge k+1+CONV_CYCLES+2·SCK_HALF_CYCLES·ADC_WIDTH. Defaults: k+97.
- busy falls the cycle after sample_valid. A trigger in that cycle is accepted, giving back-to-back frames with one IDLE cycle.
- Exactly ADC_WIDTH sck pulses per frame. sck never toggles outside SCK_HI/SCK_LO.
- Periodic mode: SAMPLE_PERIOD_CYCLES must be ≥ frame length + 1, otherwise every colliding start produces overrun.

## Configuration
- AD4008_BUSY_POLL_EN defined: CONV_WAIT exits early when sdo is low after passing through a 2-flop synchronizer. The earliest exit is CNV_HIGH_CYCLES after cnv rise. If sdo is still high at 2·CONV_CYCLES, the frame aborts: return to IDLE without sample_valid and pulse overrun.
- AD4008_BUSY_POLL_EN undefined: fixed CONV_CYCLES wait; sdo is ignored outside SCK_LO.

## Test plan
- Defaults, ADC model returns 0xA5C3; trigger at edge 10 -> cnv high edges 11–14; 16 sck pulses; sample_valid at edge 107 with sample_data=0xA5C3; busy low at 108.
- Second trigger during frame (edge 40) -> overrun pulse at 41; frame unaffected; exactly one sample_valid.
- SAMPLE_PERIOD_CYCLES=200, enable high, data 0x0001 then 0xFFFF -> sample_valid every 200 cycles with correct words; no overrun.
- rst_n low at edge 60 of a frame -> cnv=sck=busy=0 immediately; no sample_valid; a fresh trigger then yields a correct frame.
- enable dropped at edge 50 mid-frame -> frame completes with sample_valid at 107; later triggers are ignored and overrun stays 0.
- AD4008_BUSY_POLL_EN, model holds sdo high -> no sck, abort and overrun at 2·CONV_CYCLES after cnv rise; normal model -> sample_valid earlier than the fixed-wait build.
